// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit that owns the HI/LO register pair.
// Radix-2 shift-add multiply and restoring divide, one bit per cycle.
//
// Ports:
//   i_clk, i_rst        clock, asynchronous active-high reset
//   i_start, i_ope_sel  start request and op (00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   i_data_a, i_data_b  operands; i_data_a is also the move-to data
//   i_abort             drop the operation in flight
//   i_wr_hi, i_wr_lo    move-to HI/LO (IDLE only)
//   o_busy, o_done      operation in flight / result-written pulse
//   o_dz                divide-by-zero, valid with o_done
//   o_hi, o_lo          HI/LO registers
module mult_div_unit #(
    parameter int NB_BITS = 32,
    parameter int NB_OPE  = 2
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_start,
    input  logic [NB_OPE-1:0]  i_ope_sel,
    input  logic [NB_BITS-1:0] i_data_a,
    input  logic [NB_BITS-1:0] i_data_b,
    input  logic               i_abort,
    input  logic               i_wr_hi,
    input  logic               i_wr_lo,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_dz,
    output logic [NB_BITS-1:0] o_hi,
    output logic [NB_BITS-1:0] o_lo
);

    localparam int CW = $clog2(NB_BITS);
    localparam logic [CW-1:0] LAST = CW'(NB_BITS - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        FIN
    } state_t;

    state_t state, state_nxt;

    logic                 start_ok;
    logic                 is_div_q;
    logic                 sgn_q_q;
    logic                 sgn_r_q;
    logic                 dz_q;
    logic [NB_BITS-1:0]   raw_a_q;
    logic [NB_BITS-1:0]   opb_q;
    logic [2*NB_BITS-1:0] acc_q;
    logic [CW-1:0]        cnt_q;
    logic [NB_BITS-1:0]   hi_q;
    logic [NB_BITS-1:0]   lo_q;
    logic                 done_q;
    logic                 dzo_q;

    // Operand preparation at start: signed ops work on magnitudes.
    logic               op_signed;
    logic               a_neg;
    logic               b_neg;
    logic [NB_BITS-1:0] a_mag;
    logic [NB_BITS-1:0] b_mag;

    // One-iteration datapath.
    logic [NB_BITS:0]     mul_sum;
    logic [NB_BITS:0]     div_r;
    logic [NB_BITS:0]     div_trial;
    logic [2*NB_BITS-1:0] acc_step;

    // Sign-corrected results.
    logic [2*NB_BITS-1:0] prod_fix;
    logic [NB_BITS-1:0]   quo_fix;
    logic [NB_BITS-1:0]   rem_fix;

    assign start_ok  = (state == IDLE) && i_start && !i_abort;
    assign op_signed = !i_ope_sel[0];
    assign a_neg     = op_signed && i_data_a[NB_BITS-1];
    assign b_neg     = op_signed && i_data_b[NB_BITS-1];
    assign a_mag     = a_neg ? -i_data_a : i_data_a;
    assign b_mag     = b_neg ? -i_data_b : i_data_b;

    always_comb begin
        mul_sum   = {1'b0, acc_q[2*NB_BITS-1:NB_BITS]};
        if (acc_q[0])
            mul_sum = mul_sum + {1'b0, opb_q};
        div_r     = {acc_q[2*NB_BITS-1:NB_BITS], acc_q[NB_BITS-1]};
        div_trial = div_r - {1'b0, opb_q};
        if (!is_div_q)
            // Accumulate into the upper half and shift the multiplier out.
            acc_step = {mul_sum, acc_q[NB_BITS-1:1]};
        else if (div_trial[NB_BITS])
            // Trial went negative: keep the shifted remainder, bit is 0.
            acc_step = {div_r[NB_BITS-1:0], acc_q[NB_BITS-2:0], 1'b0};
        else
            acc_step = {div_trial[NB_BITS-1:0], acc_q[NB_BITS-2:0], 1'b1};
    end

    assign prod_fix = sgn_q_q ? -acc_q : acc_q;
    assign quo_fix  = sgn_q_q ? -acc_q[NB_BITS-1:0] : acc_q[NB_BITS-1:0];
    assign rem_fix  = sgn_r_q ? -acc_q[2*NB_BITS-1:NB_BITS]
                              : acc_q[2*NB_BITS-1:NB_BITS];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst)
            state <= IDLE;
        else
            state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: if (start_ok) state_nxt = RUN;
            RUN: begin
                if (i_abort)
                    state_nxt = IDLE;
                else if (cnt_q == LAST)
                    state_nxt = FIN;
            end
            FIN:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            is_div_q <= 1'b0;
            sgn_q_q  <= 1'b0;
            sgn_r_q  <= 1'b0;
            dz_q     <= 1'b0;
            raw_a_q  <= '0;
            opb_q    <= '0;
            acc_q    <= '0;
            cnt_q    <= '0;
            hi_q     <= '0;
            lo_q     <= '0;
            done_q   <= 1'b0;
            dzo_q    <= 1'b0;
        end else begin
            done_q <= 1'b0;
            dzo_q  <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (start_ok) begin
                        is_div_q <= i_ope_sel[1];
                        sgn_q_q  <= a_neg ^ b_neg;
                        sgn_r_q  <= a_neg;
                        dz_q     <= i_ope_sel[1] && (i_data_b == '0);
                        raw_a_q  <= i_data_a;
                        cnt_q    <= '0;
                        if (i_ope_sel[1]) begin
                            acc_q <= {{NB_BITS{1'b0}}, a_mag};
                            opb_q <= b_mag;
                        end else begin
                            acc_q <= {{NB_BITS{1'b0}}, b_mag};
                            opb_q <= a_mag;
                        end
                    end else begin
                        if (i_wr_hi) hi_q <= i_data_a;
                        if (i_wr_lo) lo_q <= i_data_a;
                    end
                end
                RUN: begin
                    acc_q <= acc_step;
                    cnt_q <= cnt_q + 1'b1;
                end
                FIN: begin
                    if (!i_abort) begin
                        done_q <= 1'b1;
                        dzo_q  <= dz_q;
                        if (dz_q) begin
                            hi_q <= raw_a_q;
                            lo_q <= '1;
                        end else if (is_div_q) begin
                            hi_q <= rem_fix;
                            lo_q <= quo_fix;
                        end else begin
                            hi_q <= prod_fix[2*NB_BITS-1:NB_BITS];
                            lo_q <= prod_fix[NB_BITS-1:0];
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign o_busy = (state != IDLE);
    assign o_done = done_q;
    assign o_dz   = dzo_q;
    assign o_hi   = hi_q;
    assign o_lo   = lo_q;

endmodule
